// File: rtl/dmem_lsu_if.sv
// Request/response bundle between the MEM-stage requester and dmem_lsu.
// Latency: none, this is wiring only.
// Backpressure: the requester holds req until ready; resp_valid is a single-cycle pulse.
interface dmem_lsu_if #(
    parameter int ADDR_W = 10
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [2:0]        funct3;
    logic              ready;
    logic              resp_valid;
    logic [31:0]       rdata;
    logic              fault;

    modport master (
        output req, we, addr, wdata, funct3,
        input  ready, resp_valid, rdata, fault
    );

    modport slave (
        input  req, we, addr, wdata, funct3,
        output ready, resp_valid, rdata, fault
    );
endinterface

// File: rtl/dmem_lsu.sv
// RV32I load/store data memory with byte lanes; DMEM_MISALIGN_TRAP_EN enables misalign/illegal faults.
// Latency: accept at E0, commit at E(WAIT_STATES+1), resp_valid for one cycle after the commit edge.
// Backpressure: ready only in IDLE; req while busy is ignored, so one op per WAIT_STATES+2 cycles.
module dmem_lsu #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input logic       clk,
    input logic       reset,
    dmem_lsu_if.slave bus
);
    localparam int         DEPTH = 1 << (ADDR_W - 2);
    localparam logic [3:0] LAST  = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [3:0]        cnt;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        funct3_q;
    logic [31:0]       rdata_q;
    logic              fault_q;

    logic [31:0] mem [DEPTH];

    logic              idle_rdy;
    logic              accept;
    logic              last_cycle;
    logic              commit;
    logic [1:0]        off;
    logic [1:0]        off_eff;
    logic [ADDR_W-3:0] widx;
    logic              st_legal;
    logic              ld_legal;
    logic              faulty;
    logic              wr_en;
    logic [3:0]        lane_mask;
    logic [31:0]       st_data;
    logic [31:0]       word_sh;
    logic [31:0]       ld_data;

    assign idle_rdy   = (state == IDLE) && !reset;
    assign accept     = idle_rdy && bus.req;
    assign last_cycle = (cnt == LAST);
    assign commit     = (state == ACCESS) && last_cycle;

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = ACCESS;
            ACCESS:  if (last_cycle) state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        bus.ready      = idle_rdy;
        bus.resp_valid = (state == RESP);
        bus.rdata      = rdata_q;
        bus.fault      = fault_q;
    end

    // Lane decode and load formatting on the latched request
    always_comb begin
        off      = addr_q[1:0];
        widx     = addr_q[ADDR_W-1:2];
        st_legal = funct3_q inside {3'b000, 3'b001, 3'b010};
        ld_legal = funct3_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
`ifdef DMEM_MISALIGN_TRAP_EN
        off_eff = off;
        case (funct3_q[1:0])
            2'b01:   faulty = off[0];
            2'b10:   faulty = (off != 2'b00);
            default: faulty = 1'b0;
        endcase
        if (!(we_q ? st_legal : ld_legal)) faulty = 1'b1;
`else
        faulty = 1'b0;
        // Misaligned halfword/word accesses are silently rounded down to natural alignment.
        case (funct3_q[1:0])
            2'b01:   off_eff = {off[1], 1'b0};
            2'b10:   off_eff = 2'b00;
            default: off_eff = off;
        endcase
`endif
        case (funct3_q[1:0])
            2'b00: begin
                lane_mask = 4'b0001 << off_eff;
                st_data   = {4{wdata_q[7:0]}};
            end
            2'b01: begin
                lane_mask = 4'b0011 << off_eff;
                st_data   = {2{wdata_q[15:0]}};
            end
            default: begin
                lane_mask = 4'b1111;
                st_data   = wdata_q;
            end
        endcase
        wr_en   = commit && we_q && st_legal && !faulty && !reset;
        word_sh = mem[widx] >> {off_eff, 3'b000};
        case (funct3_q)
            3'b000:  ld_data = {{24{word_sh[7]}}, word_sh[7:0]};
            3'b001:  ld_data = {{16{word_sh[15]}}, word_sh[15:0]};
            3'b010:  ld_data = word_sh;
            3'b100:  ld_data = {24'h0, word_sh[7:0]};
            3'b101:  ld_data = {16'h0, word_sh[15:0]};
            default: ld_data = 32'h0;
        endcase
        if (faulty) ld_data = 32'h0;
    end

    // Request latch, wait counter and response registers
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt      <= 4'h0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= 32'h0;
            funct3_q <= 3'b000;
            rdata_q  <= 32'h0;
            fault_q  <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= bus.we;
                addr_q   <= bus.addr;
                wdata_q  <= bus.wdata;
                funct3_q <= bus.funct3;
                cnt      <= 4'h0;
            end else if ((state == ACCESS) && !last_cycle) begin
                cnt <= cnt + 4'h1;
            end
            if (commit) begin
                fault_q <= faulty;
                if (!we_q) rdata_q <= ld_data;
            end
        end
    end

    // Storage is deliberately outside reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (lane_mask[i]) mem[widx][8*i +: 8] <= st_data[8*i +: 8];
            end
        end
    end
endmodule

// File: tb/tb_dmem_lsu.sv
// Bench for dmem_lsu: three instances (WAIT_STATES 0/2/3) checked against a byte-level memory model.
module tb_dmem_lsu;
    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic [2:0]  funct3;
    logic        ready;
    logic        resp_valid;
    logic [31:0] rdata;
    logic        fault;
    int          sel;
    int          total;
    int          bad;

    logic [7:0]  mb [3][1024];
    logic [31:0] last_rd [3];

    typedef struct {
        logic [31:0] rd;
        logic        ft;
        int          lat;
        logic        rv2;
        logic        rdy2;
        int          waits;
        logic [31:0] er;
        logic        ef;
    } res_t;

    always #5 clk = ~clk;

    dmem_lsu_if #(.ADDR_W(10)) bus0 ();
    dmem_lsu_if #(.ADDR_W(10)) bus1 ();
    dmem_lsu_if #(.ADDR_W(10)) bus2 ();

    assign bus0.req = req && (sel == 0);
    assign bus1.req = req && (sel == 1);
    assign bus2.req = req && (sel == 2);
    assign bus0.we = we;         assign bus1.we = we;         assign bus2.we = we;
    assign bus0.addr = addr;     assign bus1.addr = addr;     assign bus2.addr = addr;
    assign bus0.wdata = wdata;   assign bus1.wdata = wdata;   assign bus2.wdata = wdata;
    assign bus0.funct3 = funct3; assign bus1.funct3 = funct3; assign bus2.funct3 = funct3;

    dmem_lsu #(.ADDR_W(10), .WAIT_STATES(0)) u_ws0 (.clk(clk), .reset(reset), .bus(bus0));
    dmem_lsu #(.ADDR_W(10), .WAIT_STATES(2)) u_ws2 (.clk(clk), .reset(reset), .bus(bus1));
    dmem_lsu #(.ADDR_W(10), .WAIT_STATES(3)) u_ws3 (.clk(clk), .reset(reset), .bus(bus2));

    always_comb begin
        case (sel)
            0: begin
                ready = bus0.ready; resp_valid = bus0.resp_valid; rdata = bus0.rdata; fault = bus0.fault;
            end
            1: begin
                ready = bus1.ready; resp_valid = bus1.resp_valid; rdata = bus1.rdata; fault = bus1.fault;
            end
            default: begin
                ready = bus2.ready; resp_valid = bus2.resp_valid; rdata = bus2.rdata; fault = bus2.fault;
            end
        endcase
    end

    function automatic int ws_of(input int s);
        return (s == 0) ? 0 : (s == 1) ? 2 : 3;
    endfunction

    // Reference: byte-addressed memory, access size 1/2/4, aligned-down or trapped when misaligned
    task automatic model_op(input int s, input logic w, input logic [9:0] a, input logic [31:0] d,
                            input logic [2:0] f, output logic [31:0] er, output logic ef);
        int          size;
        int          ea;
        bit          legal;
        bit          mis;
        logic [31:0] v;
        size  = 1 << f[1:0];
        legal = w ? (f <= 3'd2) : (f inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        mis   = (int'(a) % size) != 0;
        ef    = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
        ef = !legal || mis;
`endif
        ea = int'(a) - (int'(a) % size);
        if (w) begin
            if (legal && !ef) for (int k = 0; k < size; k++) mb[s][ea + k] = d[8*k +: 8];
        end else begin
            v = 32'h0;
            if (legal && !ef) begin
                for (int k = 0; k < size; k++) v[8*k +: 8] = mb[s][ea + k];
                if (!f[2] && size < 4 && v[8*size - 1])
                    for (int b = 8*size; b < 32; b++) v[b] = 1'b1;
            end
            last_rd[s] = v;
        end
        er = last_rd[s];
    endtask

    // Drives one op on the selected instance; starts and ends on a falling edge
    task automatic do_op(input logic w, input logic [9:0] a, input logic [31:0] d,
                         input logic [2:0] f, output res_t r);
        int n;
        r.rd = 'x; r.ft = 'x; r.lat = -1; r.rv2 = 'x; r.rdy2 = 'x; r.waits = 0; r.er = 'x; r.ef = 'x;
        req = 1'b1; we = w; addr = a; wdata = d; funct3 = f;
        while (ready !== 1'b1 && r.waits < 50) begin
            @(negedge clk);
            r.waits++;
        end
        if (ready !== 1'b1) begin
            total++; bad++;
            $display("FAIL accept_timeout: ready=%b, required 1", ready);
            req = 1'b0;
            return;
        end
        model_op(sel, w, a, d, f, r.er, r.ef);
        @(posedge clk);
        #1;
        req = 1'b0; we = 1'($urandom); addr = 10'($urandom); wdata = $urandom; funct3 = 3'($urandom);
        n = 0;
        do begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end while (resp_valid !== 1'b1 && n < 40);
        if (resp_valid !== 1'b1) begin
            total++; bad++;
            $display("FAIL resp_timeout: resp_valid=%b after %0d cycles, required 1", resp_valid, n);
            return;
        end
        r.lat = n; r.rd = rdata; r.ft = fault;
        @(negedge clk);
        r.rv2 = resp_valid; r.rdy2 = ready;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            total++; if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d]: got %b, required 0", s, ready); end
            total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp[%0d]: got %b, required 0", s, resp_valid); end
            total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata[%0d]: got %h, required 0", s, rdata); end
            total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault[%0d]: got %b, required 0", s, fault); end
        end
        reset = 1'b0;
        for (int s = 0; s < 3; s++) last_rd[s] = 32'h0;
        @(negedge clk);
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            total++; if (ready !== 1'b1) begin bad++; $display("FAIL release_ready[%0d]: got %b, required 1", s, ready); end
        end
        @(negedge clk);
    endtask

    task automatic test_word();
        res_t r;
        sel = 0;
        do_op(1'b1, 10'h10, 32'hDEADBEEF, 3'b010, r);
        total++; if (r.lat !== 1) begin bad++; $display("FAIL sw_latency: got %0d, required 1", r.lat); end
        total++; if (r.rv2 !== 1'b0) begin bad++; $display("FAIL sw_pulse: resp_valid %b, required 0", r.rv2); end
        total++; if (r.rdy2 !== 1'b1) begin bad++; $display("FAIL sw_ready_back: got %b, required 1", r.rdy2); end
        do_op(1'b0, 10'h10, 32'h0, 3'b010, r);
        total++; if (r.lat !== 1) begin bad++; $display("FAIL lw_latency: got %0d, required 1", r.lat); end
        total++; if (r.rd !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_data: got %h, required deadbeef", r.rd); end
        total++; if (r.ft !== 1'b0) begin bad++; $display("FAIL lw_fault: got %b, required 0", r.ft); end
    endtask

    task automatic test_byte_lanes();
        res_t        r;
        logic [2:0]  f3s  [5] = '{3'b010, 3'b000, 3'b100, 3'b001, 3'b101};
        logic [9:0]  adrs [5] = '{10'h20, 10'h23, 10'h23, 10'h22, 10'h20};
        logic [31:0] exps [5] = '{32'hF0223344, 32'hFFFFFFF0, 32'h000000F0, 32'hFFFFF022, 32'h00003344};
        sel = 0;
        do_op(1'b1, 10'h20, 32'h11223344, 3'b010, r);
        do_op(1'b1, 10'h23, 32'h000000F0, 3'b000, r);
        for (int i = 0; i < 5; i++) begin
            do_op(1'b0, adrs[i], 32'h0, f3s[i], r);
            total++;
            if (r.rd !== exps[i]) begin
                bad++; $display("FAIL lanes[%0d] f3=%b @%h: got %h, required %h", i, f3s[i], adrs[i], r.rd, exps[i]);
            end
        end
    endtask

    task automatic test_wait_states();
        res_t        r;
        logic [31:0] er;
        logic        ef;
        int          n;
        int          rdy_low;
        sel = 2;
        do_op(1'b1, 10'h50, 32'hCAFEF00D, 3'b010, r);
        total++; if (r.lat !== 4) begin bad++; $display("FAIL ws3_latency: got %0d, required 4", r.lat); end
        // Load accepted, then req stays high with a conflicting store while busy
        req = 1'b1; we = 1'b0; addr = 10'h50; wdata = 32'h0; funct3 = 3'b010;
        model_op(2, 1'b0, 10'h50, 32'h0, 3'b010, er, ef);
        @(posedge clk);
        #1;
        we = 1'b1; wdata = 32'h0;
        n = 0; rdy_low = 0;
        while (n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (resp_valid === 1'b1) break;
            if (ready === 1'b0) rdy_low++;
        end
        req = 1'b0;
        total++; if (n !== 4) begin bad++; $display("FAIL ws3_held_latency: got %0d, required 4", n); end
        total++; if (rdy_low !== 3) begin bad++; $display("FAIL ws3_ready_low: got %0d cycles, required 3", rdy_low); end
        total++; if (rdata !== er) begin bad++; $display("FAIL ws3_load_data: got %h, required %h", rdata, er); end
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL ws3_ready_back: got %b, required 1", ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL ws3_pulse: got %b, required 0", resp_valid); end
        do_op(1'b0, 10'h50, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'hCAFEF00D) begin bad++; $display("FAIL ws3_held_not_taken: got %h, required cafef00d", r.rd); end
    endtask

    task automatic test_misalign();
        res_t r;
        sel = 0;
`ifdef DMEM_MISALIGN_TRAP_EN
        do_op(1'b1, 10'h30, 32'h0BADF00D, 3'b010, r);
        do_op(1'b1, 10'h31, 32'hAAAAAAAA, 3'b010, r);
        total++; if (r.ft !== 1'b1) begin bad++; $display("FAIL mis_sw_fault: got %b, required 1", r.ft); end
        do_op(1'b0, 10'h30, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'h0BADF00D) begin bad++; $display("FAIL mis_sw_nowrite: got %h, required 0badf00d", r.rd); end
        total++; if (r.ft !== 1'b0) begin bad++; $display("FAIL mis_aligned_fault: got %b, required 0", r.ft); end
        do_op(1'b0, 10'h31, 32'h0, 3'b001, r);
        total++; if (r.ft !== 1'b1) begin bad++; $display("FAIL mis_lh_fault: got %b, required 1", r.ft); end
        total++; if (r.rd !== 32'h0) begin bad++; $display("FAIL mis_lh_data: got %h, required 0", r.rd); end
        do_op(1'b0, 10'h30, 32'h0, 3'b011, r);
        total++; if (r.ft !== 1'b1) begin bad++; $display("FAIL illegal_fault: got %b, required 1", r.ft); end
        do_op(1'b0, 10'h30, 32'h0, 3'b010, r);
        total++; if (r.ft !== 1'b0) begin bad++; $display("FAIL fault_clears: got %b, required 0", r.ft); end
`else
        do_op(1'b1, 10'h31, 32'h12345678, 3'b010, r);
        total++; if (r.ft !== 1'b0) begin bad++; $display("FAIL mis_sw_fault: got %b, required 0", r.ft); end
        do_op(1'b0, 10'h30, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'h12345678) begin bad++; $display("FAIL mis_sw_forced: got %h, required 12345678", r.rd); end
        do_op(1'b0, 10'h33, 32'h0, 3'b001, r);
        total++; if (r.rd !== 32'h00001234) begin bad++; $display("FAIL mis_lh_forced: got %h, required 00001234", r.rd); end
        total++; if (r.ft !== 1'b0) begin bad++; $display("FAIL mis_lh_fault: got %b, required 0", r.ft); end
        do_op(1'b1, 10'h30, 32'hFFFFFFFF, 3'b011, r);
        do_op(1'b0, 10'h30, 32'h0, 3'b011, r);
        total++; if (r.rd !== 32'h0) begin bad++; $display("FAIL illegal_load: got %h, required 0", r.rd); end
        do_op(1'b0, 10'h30, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'h12345678) begin bad++; $display("FAIL illegal_store_nowrite: got %h, required 12345678", r.rd); end
`endif
    endtask

    task automatic test_reset_mid_store();
        res_t r;
        sel = 1;
        do_op(1'b1, 10'h40, 32'h0, 3'b010, r);
        do_op(1'b1, 10'h44, 32'h77, 3'b010, r);
        do_op(1'b0, 10'h44, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'h77) begin bad++; $display("FAIL ws2_pre_load: got %h, required 00000077", r.rd); end
        req = 1'b1; we = 1'b1; addr = 10'h40; wdata = 32'h55555555; funct3 = 3'b010;
        @(posedge clk);
        #1;
        req = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_resp: got %b, required 0", resp_valid); end
        total++; if (ready !== 1'b0) begin bad++; $display("FAIL abort_ready: got %b, required 0", ready); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL abort_rdata: got %h, required 0", rdata); end
        total++; if (fault !== 1'b0) begin bad++; $display("FAIL abort_fault: got %b, required 0", fault); end
        reset = 1'b0;
        for (int s = 0; s < 3; s++) last_rd[s] = 32'h0;
        @(negedge clk);
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL abort_ready_back: got %b, required 1", ready); end
        total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL abort_no_resp: got %b, required 0", resp_valid); end
        do_op(1'b0, 10'h40, 32'h0, 3'b010, r);
        total++; if (r.rd !== 32'h0) begin bad++; $display("FAIL abort_nowrite: got %h, required 0", r.rd); end
        total++; if (r.lat !== 3) begin bad++; $display("FAIL ws2_latency: got %0d, required 3", r.lat); end
    endtask

    task automatic test_back_to_back();
        res_t r;
        for (int s = 0; s < 3; s += 2) begin
            sel = s;
            do_op(1'b1, 10'h60, 32'hA5A50F0F, 3'b010, r);
            do_op(1'b0, 10'h61, 32'h0, 3'b100, r);
            total++; if (r.waits !== 0) begin bad++; $display("FAIL b2b_wait[%0d]: got %0d, required 0", s, r.waits); end
            total++; if (r.lat !== ws_of(s) + 1) begin bad++; $display("FAIL b2b_lat[%0d]: got %0d, required %0d", s, r.lat, ws_of(s) + 1); end
            total++; if (r.rd !== 32'h0000000F) begin bad++; $display("FAIL b2b_data[%0d]: got %h, required 0000000f", s, r.rd); end
        end
    endtask

    task automatic test_random();
        res_t        r;
        logic        w;
        logic [9:0]  a;
        logic [2:0]  f;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            for (int i = 0; i < 16; i++) do_op(1'b1, 10'(10'h100 + 4 * i), $urandom, 3'b010, r);
            for (int i = 0; i < 40; i++) begin
                w = 1'($urandom);
                a = 10'(10'h100 + $urandom_range(0, 63));
                f = 3'($urandom);
                do_op(w, a, $urandom, f, r);
                total++; if (r.rd !== r.er) begin bad++; $display("FAIL rnd_rdata[%0d.%0d] we=%b f3=%b @%h: got %h, required %h", s, i, w, f, a, r.rd, r.er); end
                total++; if (r.ft !== r.ef) begin bad++; $display("FAIL rnd_fault[%0d.%0d] we=%b f3=%b @%h: got %b, required %b", s, i, w, f, a, r.ft, r.ef); end
                total++; if (r.lat !== ws_of(s) + 1) begin bad++; $display("FAIL rnd_lat[%0d.%0d]: got %0d, required %0d", s, i, r.lat, ws_of(s) + 1); end
                total++; if (r.rv2 !== 1'b0 || r.rdy2 !== 1'b1) begin bad++; $display("FAIL rnd_after[%0d.%0d]: resp_valid=%b ready=%b, required 0/1", s, i, r.rv2, r.rdy2); end
            end
        end
    endtask

    initial begin
        total = 0; bad = 0; sel = 0; reset = 1'b1;
        req = 1'b0; we = 1'b0; addr = '0; wdata = '0; funct3 = '0;
        for (int s = 0; s < 3; s++) begin
            last_rd[s] = 32'h0;
            for (int b = 0; b < 1024; b++) mb[s][b] = 8'h0;
        end
        test_reset();
        test_word();
        test_byte_lanes();
        test_wait_states();
        test_misalign();
        test_reset_mid_store();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule

// File: doc/dmem_lsu.md
# dmem_lsu

- Parametrised load/store data memory for the pipelined RISC-V core.
- Replaces the single-cycle combinational data memory with a registered, handshaked memory stage:
  - byte-lane placement by address offset;
  - full RV32I load set (LB/LH/LW/LBU/LHU) with sign/zero extension;
  - programmable wait states.
- Sits between the EX/MEM pipeline register and the MEM/WB register. The hazard unit stalls the pipe while `ready` or `resp_valid` is pending.

## Interface
- `ADDR_W`, default 10: byte-address width. Storage is 2^(ADDR_W-2) 32-bit words.
- `WAIT_STATES`, default 0: extra access cycles per operation, 0..15.
- `clk` in, 1: clock, rising edge.
- `reset` in, 1: synchronous, active-high.
- `req` in, 1: request valid.
- `we` in, 1: 1 = store, 0 = load.
- `addr` in, ADDR_W: byte address (ALU result LSBs).
- `wdata` in, 32: store data, right-aligned (rs2).
- `funct3` in, 3: instruction bits 14:12.
- `ready` out, 1: request accepted this cycle when `req && ready`.
- `resp_valid` out, 1: one-cycle completion pulse for both loads and stores.
- `rdata` out, 32: formatted load data. Valid while `resp_valid`.
- `fault` out, 1: misaligned or illegal access. Valid while `resp_valid`.

## Operation
- FSM states are IDLE, ACCESS and RESP.
- **IDLE:** `ready`=1.
  - On `req`: latch `we`, `addr`, `wdata` and `funct3`, clear the wait counter, go to ACCESS.
- **ACCESS:** lasts WAIT_STATES+1 cycles, counted by a 4-bit counter. On the final cycle, the commit edge:
  - a store writes the enabled byte lanes;
  - a load captures formatted data into the `rdata` register;
  - the FSM goes to RESP.
- **RESP:** `resp_valid`=1 for exactly one cycle, then IDLE. `ready`=0 in ACCESS and RESP.
- Lane offset: `off` = latched `addr[1:0]`. Word index = `addr[ADDR_W-1:2]`.
- Stores:
  - SB (000): lane mask 0001<<`off`, data `wdata[7:0]` replicated ×4.
  - SH (001): mask 0011<<`off`, data `wdata[15:0]` replicated ×2.
  - SW (010): mask 1111.
  - Other funct3 values are illegal: no write.
- Loads pick the word, shift right by 8·`off`, then:
  - LB (000): sign-extend bit 7.
  - LH (001): sign-extend bit 15.
  - LW (010): full word.
  - LBU (100): zero-extend 8 bits.
  - LHU (101): zero-extend 16 bits.
  - Other funct3 values are illegal: `rdata`=0.
- `rdata` holds its value until the next load commit. `fault` is cleared at every commit edge, then set if the access is faulty.
- Storage contents are not affected by `reset`. They are zero at time 0 in simulation.

## Timing
- Reset values:
  - state IDLE, counter 0;
  - `resp_valid`=0, `rdata`=0, `fault`=0;
  - `ready`=0 while `reset` is high, 1 in the first cycle after release.
- Latency: acceptance edge E0, commit at edge E(WAIT_STATES+1), `resp_valid` high in the following cycle, `ready` returns at E(WAIT_STATES+2).
- Throughput: one operation per WAIT_STATES+2 cycles.
- `req` while not `ready` is ignored. The requester holds `req` until it sees `ready`.
- `addr`, `wdata`, `funct3` may change freely after acceptance because they are latched.
- Reset mid-operation:
  - `reset` has priority at every edge, including the commit edge;
  - a store whose commit edge coincides with `reset` is not written;
  - no `resp_valid` is produced for an aborted operation.
- A load that follows a store to the same word sees the new data, because the store commits before the load is accepted.

## Configuration
- `DMEM_MISALIGN_TRAP_EN` defined:
  - misaligned accesses set `fault`=1 at commit, perform no write, and return `rdata`=0;
    - halfword with `addr[0]`=1;
    - word with `addr[1:0]`≠00;
  - illegal funct3 also sets `fault`=1.
- Undefined:
  - `fault` is tied to 0;
  - misaligned accesses are forced aligned: SH/LH/LHU clear `off[0]`, SW/LW clear `off[1:0]`;
  - illegal funct3 gives no write and `rdata`=0 with no fault.

## Test plan
- **Word store then load:** WAIT_STATES=0. SW 0xDEADBEEF @0x10, then LW @0x10 → `rdata`=0xDEADBEEF. Each `resp_valid` comes 1 cycle after the acceptance edge. `ready` is low for 2 cycles per operation.
- **Byte lanes and extension:** SW 0x11223344 @0x20, SB 0x000000F0 @0x23, then:
  - LW @0x20 → 0xF0223344;
  - LB @0x23 → 0xFFFFFFF0;
  - LBU @0x23 → 0x000000F0;
  - LH @0x22 → 0xFFFFF022;
  - LHU @0x20 → 0x00003344.
- **Wait states:** WAIT_STATES=3. LW accepted at E0 → commit at E4, `resp_valid` high for one cycle after E4, `ready` high again after E5. A `req` held during ACCESS is not accepted.
- **Misaligned with macro:** SW 0xAAAAAAAA @0x31 → `fault`=1, word 0x30 unchanged. LH @0x31 → `fault`=1, `rdata`=0. The next aligned access → `fault`=0.
- **Misaligned without macro:** SW 0x12345678 @0x31 writes word 0x30. LH @0x33 returns sign-extended bits [31:16] = 0x00001234. `fault` is always 0.
- **Reset mid-store:** WAIT_STATES=2. SW 0x55555555 @0x40 over 0x0, with `reset` high on the commit edge → word stays 0, no `resp_valid`, all outputs at reset values, `ready`=1 after release.
